register_reader: RTL and testbench



---
 rtl/register_reader.sv | 111 +++++++++++
 tb/tb_register_reader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/register_reader.sv
// register_reader: snapshots a register bank on start, then streams a window
// of it out one word per valid/ready transfer.
module register_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                           clock,
  input  logic                           rd_reset,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] rd_regs_in,
  input  logic                           rd_start,
  input  logic [IDX_WIDTH-1:0]           rd_first,
  input  logic [IDX_WIDTH:0]             rd_count,
  input  logic                           rd_ready,
  output logic                           rd_valid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [IDX_WIDTH-1:0]           rd_index,
  output logic                           rd_last,
  output logic                           rd_busy,
  output logic                           rd_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH:0] MAX_COUNT = (IDX_WIDTH+1)'(NUM_REGS);

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   snapshot [NUM_REGS];
  logic [IDX_WIDTH-1:0]    index;
  logic [IDX_WIDTH:0]      remaining;
  logic [IDX_WIDTH:0]      eff_count;
  logic                    load;
  logic                    transfer;

  // Clamp the requested word count to the size of the bank.
  always_comb begin
    if (rd_count > MAX_COUNT) eff_count = MAX_COUNT;
    else                      eff_count = rd_count;
  end

  assign load     = (state == IDLE) && rd_start && (eff_count != '0);
  assign transfer = rd_valid && rd_ready;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    if (rd_reset) state <= IDLE;
    else          state <= state_next;
  end

  // Snapshot, current index and words-remaining counter.
  always_ff @(posedge clock) begin
    if (rd_reset) begin
      // NOTE: the snapshot is a small flop array, so clearing it on reset is
      // cheap; a RAM-based bank would not be reset this way.
      for (int i = 0; i < NUM_REGS; i++) snapshot[i] <= '0;
      index     <= '0;
      remaining <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_REGS; i++)
        snapshot[i] <= rd_regs_in[i*DATA_WIDTH +: DATA_WIDTH];
      index     <= rd_first;
      remaining <= eff_count;
    end else if (transfer && (remaining > (IDX_WIDTH+1)'(1))) begin
      index     <= index + IDX_WIDTH'(1);   // wraps naturally: NUM_REGS is 2^IDX_WIDTH
      remaining <= remaining - (IDX_WIDTH+1)'(1);
    end
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    state_next = state;
    rd_valid   = 1'b0;
    rd_data    = '0;
    rd_index   = '0;
    rd_last    = 1'b0;
    rd_busy    = 1'b0;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_start) begin
          if (eff_count == '0) state_next = DONE;
          else                 state_next = SEND;
        end
      end
      SEND: begin
        rd_valid = 1'b1;
        rd_busy  = 1'b1;
        rd_data  = snapshot[index];
        rd_index = index;
        rd_last  = (remaining == (IDX_WIDTH+1)'(1));
        if (rd_ready && rd_last) state_next = DONE;
      end
      DONE: begin
        rd_busy    = 1'b1;
        rd_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_register_reader.sv
// tb_register_reader: directed-vector bench for register_reader.
module tb_register_reader;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clock = 1'b0;
  logic              rd_reset;
  logic [NR*DW-1:0]  rd_regs_in;
  logic              rd_start;
  logic [IW-1:0]     rd_first;
  logic [IW:0]       rd_count;
  logic              rd_ready;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic [IW-1:0]     rd_index;
  logic              rd_last;
  logic              rd_busy;
  logic              rd_done;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] bank [NR];

  register_reader #(.DATA_WIDTH(DW), .NUM_REGS(NR), .IDX_WIDTH(IW)) dut (
    .clock      (clock),
    .rd_reset   (rd_reset),
    .rd_regs_in (rd_regs_in),
    .rd_start   (rd_start),
    .rd_first   (rd_first),
    .rd_count   (rd_count),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_index   (rd_index),
    .rd_last    (rd_last),
    .rd_busy    (rd_busy),
    .rd_done    (rd_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_bank();
    rd_regs_in = {bank[3], bank[2], bank[1], bank[0]};
  endtask

  task automatic start(input logic [IW-1:0] first, input logic [IW:0] count);
    rd_first = first;
    rd_count = count;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, rd_valid, 0);
    check({tag, "_data"},  rd_data,  0);
    check({tag, "_index"}, rd_index, 0);
    check({tag, "_last"},  rd_last,  0);
    check({tag, "_busy"},  rd_busy,  0);
    check({tag, "_done"},  rd_done,  0);
  endtask

  // Expect n words starting at first (rd_ready high), then the DONE cycle and return to IDLE.
  task automatic expect_stream(input string tag, input int first, input int n,
                               input logic [DW-1:0] ref_bank [NR]);
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, rd_valid, 1);
      check({tag, "_busy"},  rd_busy,  1);
      check({tag, "_data"},  rd_data,  ref_bank[(first + i) % NR]);
      check({tag, "_index"}, rd_index, (first + i) % NR);
      check({tag, "_last"},  rd_last,  (i == n - 1) ? 1 : 0);
      tick();
    end
    check({tag, "_done_pulse"}, rd_done,  1);
    check({tag, "_done_busy"},  rd_busy,  1);
    check({tag, "_done_valid"}, rd_valid, 0);
    tick();
    check({tag, "_idle_done"},  rd_done,  0);
    check({tag, "_idle_busy"},  rd_busy,  0);
    check({tag, "_idle_valid"}, rd_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] start_bank [NR];
    bank[0] = 16'h0032;
    bank[1] = 16'hFD92;
    bank[2] = 16'hFE13;
    bank[3] = 16'h0090;

    // Reset with random inputs.
    rd_reset   = 1'b1;
    rd_regs_in = {$urandom, $urandom};
    rd_start   = 1'($urandom);
    rd_first   = IW'($urandom);
    rd_count   = (IW+1)'($urandom);
    rd_ready   = 1'($urandom);
    tick();
    tick();
    check_quiet("reset");

    // Idle without start.
    rd_reset = 1'b0;
    rd_start = 1'b0;
    rd_ready = 1'b1;
    load_bank();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid", rd_valid, 0);
      check("idle_busy",  rd_busy,  0);
    end

    // Full burst 0..3, explicit first-word values.
    start(0, 4);
    check("full_w0_data", rd_data, 16'h0032);
    expect_stream("full", 0, 4, bank);

    // Wrap and snapshot: reg 0 changes after the start edge.
    start_bank = bank;
    start(3, 3);
    rd_regs_in[15:0] = 16'hFF03;
    check("wrap_w0_data", rd_data, 16'h0090);
    expect_stream("wrap", 3, 3, start_bank);
    load_bank();

    // Backpressure with ignored start pulses.
    rd_ready = 1'b0;
    start(1, 2);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", rd_valid, 1);
      check("bp_hold_data",  rd_data,  16'hFD92);
      check("bp_hold_index", rd_index, 1);
      check("bp_hold_last",  rd_last,  0);
      rd_start = (i < 2);
      rd_first = 2'd0;
      rd_count = 3'd4;
      if (i == 2) rd_ready = 1'b1;
      tick();
    end
    rd_start = 1'b0;
    check("bp_w1_data", rd_data, 16'hFE13);
    expect_stream("bp", 2, 1, bank);

    // Count 0: straight to DONE.
    start(0, 0);
    check("cnt0_valid", rd_valid, 0);
    check("cnt0_done",  rd_done,  1);
    tick();
    check("cnt0_idle_done", rd_done, 0);
    check("cnt0_idle_busy", rd_busy, 0);

    // Count 7 clamps to 4 words.
    start(0, 7);
    expect_stream("cnt7", 0, 4, bank);

    // Reset mid-burst after two transfers.
    start(0, 4);
    check("mid_w0_data", rd_data, 16'h0032);
    tick();
    check("mid_w1_data", rd_data, 16'hFD92);
    tick();
    check("mid_w2_data", rd_data, 16'hFE13);
    rd_reset = 1'b1;
    tick();
    check_quiet("mid_reset");
    rd_reset = 1'b0;
    tick();
    check("mid_no_done",  rd_done,  0);
    check("mid_no_valid", rd_valid, 0);

    // Normal burst after the abandoned one.
    start(1, 2);
    expect_stream("after", 1, 2, bank);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
